tmp_meas_ctrl: RTL and testbench

TMP_MEAS_CTRL -- requirements
Module: tmp_meas_ctrl

---
 rtl/tmp_meas_ctrl.sv | 179 +++++++++++++++++
 tb/tb_tmp_meas_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmp_meas_ctrl.sv
// rtl/tmp_meas_ctrl.sv - temperature sensor measurement controller
// Sequences sensor reset/settle, counts ones over a qualified-sample window, hands off the result.
module tmp_meas_ctrl #(
  parameter  int RST_CYC    = 4,
  parameter  int SETTLE_CYC = 64,
  parameter  int WIN_LOG2   = 10,
  localparam int RES_W      = WIN_LOG2 + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_continuous,
  input  logic [15:0]      i_period,
  input  logic             i_abort,
  input  logic             i_sens_bit,
  input  logic             i_sens_valid,
  output logic             o_sens_rst,
  output logic             o_sens_en,
  output logic             o_busy,
  output logic [RES_W-1:0] o_result,
  output logic             o_result_valid,
  input  logic             i_result_ready,
  output logic             o_overrun
);

  localparam int PH_MAX = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0]     RST_LAST    = PH_W'(RST_CYC - 1);
  localparam logic [PH_W-1:0]     SETTLE_LAST = PH_W'(SETTLE_CYC - 1);
  localparam logic [WIN_LOG2-1:0] SMP_LAST    = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SENS_RST,
    S_SETTLE,
    S_MEASURE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PH_W-1:0]     r_ph_cnt;
  logic [PH_W-1:0]     w_ph_cnt_nxt;
  logic [WIN_LOG2-1:0] r_smp_cnt;
  logic [WIN_LOG2-1:0] w_smp_cnt_nxt;
  logic [RES_W-1:0]    r_ones_cnt;
  logic [RES_W-1:0]    w_ones_cnt_nxt;
  logic [RES_W-1:0]    w_final_ones;
  logic [15:0]         r_tmr;
  logic                w_tmr_exp;
  logic                w_trig;
  logic                w_accept;
  logic                w_load;

  logic                r_sens_rst;
  logic                r_sens_en;
  logic                r_busy;
  logic [RES_W-1:0]    r_result;
  logic                r_result_valid;
  logic                r_overrun;

  // Timer saturates, so an expiry seen while busy stays pending until the next IDLE cycle.
  assign w_tmr_exp    = (r_tmr >= i_period);
  assign w_trig       = i_start | (i_continuous & w_tmr_exp);
  assign w_final_ones = r_ones_cnt + RES_W'(i_sens_bit);

  always_comb begin
    w_state_nxt    = r_state;
    w_ph_cnt_nxt   = r_ph_cnt;
    w_smp_cnt_nxt  = r_smp_cnt;
    w_ones_cnt_nxt = r_ones_cnt;
    w_accept       = 1'b0;
    w_load         = 1'b0;
    if (i_abort && (r_state != S_IDLE)) begin
      w_state_nxt    = S_IDLE;
      w_ph_cnt_nxt   = '0;
      w_smp_cnt_nxt  = '0;
      w_ones_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!i_abort && w_trig) begin
            w_accept     = 1'b1;
            w_state_nxt  = S_SENS_RST;
            w_ph_cnt_nxt = '0;
          end
        end
        S_SENS_RST: begin
          if (r_ph_cnt == RST_LAST) begin
            w_state_nxt  = S_SETTLE;
            w_ph_cnt_nxt = '0;
          end else begin
            w_ph_cnt_nxt = r_ph_cnt + PH_W'(1);
          end
        end
        S_SETTLE: begin
          if (r_ph_cnt == SETTLE_LAST) begin
            w_state_nxt    = S_MEASURE;
            w_ph_cnt_nxt   = '0;
            w_smp_cnt_nxt  = '0;
            w_ones_cnt_nxt = '0;
          end else begin
            w_ph_cnt_nxt = r_ph_cnt + PH_W'(1);
          end
        end
        S_MEASURE: begin
          if (i_sens_valid) begin
            if (r_smp_cnt == SMP_LAST) begin
              w_load         = 1'b1;
              w_state_nxt    = S_IDLE;
              w_smp_cnt_nxt  = '0;
              w_ones_cnt_nxt = '0;
            end else begin
              w_smp_cnt_nxt  = r_smp_cnt + WIN_LOG2'(1);
              w_ones_cnt_nxt = w_final_ones;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_ph_cnt   <= '0;
      r_smp_cnt  <= '0;
      r_ones_cnt <= '0;
      r_sens_rst <= 1'b1;
      r_sens_en  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ph_cnt   <= w_ph_cnt_nxt;
      r_smp_cnt  <= w_smp_cnt_nxt;
      r_ones_cnt <= w_ones_cnt_nxt;
      r_sens_rst <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_SENS_RST);
      r_sens_en  <= (w_state_nxt != S_IDLE);
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmr <= '0;
    end else if (w_accept) begin
      r_tmr <= 16'd1;
    end else if (r_tmr != 16'hFFFF) begin
      r_tmr <= r_tmr + 16'd1;
    end
  end

  // A load on the handshake edge consumes the old value, so overrun needs ready low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_overrun      <= 1'b0;
    end else if (w_load) begin
      r_result       <= w_final_ones;
      r_result_valid <= 1'b1;
      if (r_result_valid && !i_result_ready) begin
        r_overrun <= 1'b1;
      end
    end else if (r_result_valid && i_result_ready) begin
      r_result_valid <= 1'b0;
    end
  end

  assign o_sens_rst     = r_sens_rst;
  assign o_sens_en      = r_sens_en;
  assign o_busy         = r_busy;
  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;
  assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_tmp_meas_ctrl.sv
// tb/tb_tmp_meas_ctrl.sv - self-checking bench for tmp_meas_ctrl
module tb_tmp_meas_ctrl;
  localparam int RST = 4;
  localparam int SET = 8;
  localparam int WL  = 4;
  localparam int WIN = 16;
  localparam int RW  = WL + 1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          continuous;
  logic [15:0]   period;
  logic          abort;
  logic          sens_bit;
  logic          sens_valid;
  logic          result_ready;
  logic          o_sens_rst;
  logic          o_sens_en;
  logic          o_busy;
  logic [RW-1:0] o_result;
  logic          o_result_valid;
  logic          o_overrun;

  int n_tot;
  int n_bad;

  tmp_meas_ctrl #(.RST_CYC(RST), .SETTLE_CYC(SET), .WIN_LOG2(WL)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_continuous   (continuous),
    .i_period       (period),
    .i_abort        (abort),
    .i_sens_bit     (sens_bit),
    .i_sens_valid   (sens_valid),
    .o_sens_rst     (o_sens_rst),
    .o_sens_en      (o_sens_en),
    .o_busy         (o_busy),
    .o_result       (o_result),
    .o_result_valid (o_result_valid),
    .i_result_ready (result_ready),
    .o_overrun      (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level reference: a measurement is a start edge plus a list of qualified samples.
  int e_cnt;
  int m_busy;
  int m_t0;
  int m_n;
  int m_ones;
  int m_res;
  int m_rv;
  int m_ovr;
  int m_tmr;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_t0 = 0; m_n = 0; m_ones = 0;
    m_res = 0; m_rv = 0; m_ovr = 0; m_tmr = 0;
  endtask

  task automatic model_step();
    int trig;
    int acc;
    int load;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_cnt++;
    trig = (start || (continuous && (m_tmr >= int'(period)))) ? 1 : 0;
    acc  = 0;
    load = 0;
    if (m_busy == 0) begin
      if (!abort && trig != 0) begin
        acc = 1; m_busy = 1; m_t0 = e_cnt; m_n = 0; m_ones = 0;
      end
    end else if (abort) begin
      m_busy = 0;
    end else if ((e_cnt - m_t0) > RST + SET && sens_valid) begin
      m_n++;
      m_ones += int'(sens_bit);
      if (m_n == WIN) begin
        load = 1; m_busy = 0;
      end
    end
    if (load != 0) begin
      if (m_rv != 0 && !result_ready) m_ovr = 1;
      m_res = m_ones;
      m_rv  = 1;
    end else if (m_rv != 0 && result_ready) begin
      m_rv = 0;
    end
    if (acc != 0) m_tmr = 1;
    else if (m_tmr < 65535) m_tmr++;
  endtask

  task automatic check_model();
    int exp_srst;
    exp_srst = (m_busy == 0 || (e_cnt - m_t0) < RST) ? 1 : 0;
    chk("busy", int'(o_busy), m_busy);
    chk("sens_en", int'(o_sens_en), m_busy);
    chk("sens_rst", int'(o_sens_rst), exp_srst);
    chk("result_valid", int'(o_result_valid), m_rv);
    chk("result", int'(o_result), m_res);
    chk("overrun", int'(o_overrun), m_ovr);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    int vmode;
    int bmode;
    int exp_res;
    int exp_lat;
  } vec_t;

  task automatic run_vec(input int vmode, input int bmode, output int lat, output int res);
    int q;
    int m;
    logic v;
    logic b;
    start = 1'b1; result_ready = 1'b1; sens_valid = 1'b0;
    cycle();
    start = 1'b0;
    q = 0; lat = -1; res = -1;
    for (int k = 1; k <= 80 && lat < 0; k++) begin
      if (k > RST + SET) begin
        m = k - RST - SET - 1;
        v = (vmode == 0) || (m % 2 == 0);
        case (bmode)
          0:       b = 1'b1;
          1:       b = 1'b0;
          2:       b = (q % 2 == 0);
          default: b = (q < 5);
        endcase
        if (!v) b = 1'($urandom_range(0, 1));
        if (v) q++;
      end else begin
        v = 1'($urandom_range(0, 1));
        b = 1'($urandom_range(0, 1));
      end
      sens_valid = v; sens_bit = b;
      cycle();
      if (o_result_valid) begin
        lat = k; res = int'(o_result);
      end
    end
    sens_valid = 1'b0;
    chk("busy_after_result", int'(o_busy), 0);
    cycle();
  endtask

  vec_t vecs[5];
  int   lat;
  int   res;
  int   k1;
  int   k2;

  initial begin
    n_tot = 0; n_bad = 0; e_cnt = 0;
    model_reset();
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; period = 16'd0; abort = 1'b0;
    sens_bit = 1'b0; sens_valid = 1'b0; result_ready = 1'b0;

    vecs[0] = '{vmode: 0, bmode: 0, exp_res: 16, exp_lat: 28};
    vecs[1] = '{vmode: 0, bmode: 1, exp_res: 0,  exp_lat: 28};
    vecs[2] = '{vmode: 1, bmode: 2, exp_res: 8,  exp_lat: 43};
    vecs[3] = '{vmode: 0, bmode: 3, exp_res: 5,  exp_lat: 28};
    vecs[4] = '{vmode: 1, bmode: 0, exp_res: 16, exp_lat: 43};

    repeat (2) cycle();
    chk("rst_sens_rst", int'(o_sens_rst), 1);
    chk("rst_sens_en", int'(o_sens_en), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_result", int'(o_result), 0);
    chk("rst_result_valid", int'(o_result_valid), 0);
    chk("rst_overrun", int'(o_overrun), 0);
    rst_n = 1'b1;
    cycle();

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i].vmode, vecs[i].bmode, lat, res);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
    end

    // Abort on the fifth MEASURE cycle.
    result_ready = 1'b1; cycle(); result_ready = 1'b0;
    start = 1'b1; sens_valid = 1'b1; sens_bit = 1'b1;
    cycle();
    start = 1'b0;
    repeat (RST + SET + 4) cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_busy", int'(o_busy), 0);
    chk("abort_sens_rst", int'(o_sens_rst), 1);
    chk("abort_sens_en", int'(o_sens_en), 0);
    chk("abort_result_valid", int'(o_result_valid), 0);
    repeat (30) cycle();
    chk("abort_no_late_result", int'(o_result_valid), 0);

    // Continuous mode with no consumer: second result overwrites the first.
    period = 16'd40; continuous = 1'b1; sens_valid = 1'b1;
    k1 = -1; k2 = -1;
    for (int k = 0; k < 150 && k2 < 0; k++) begin
      sens_bit = 1'($urandom_range(0, 1));
      cycle();
      if (k1 < 0 && o_result_valid) k1 = k;
      if (k2 < 0 && o_overrun) k2 = k;
    end
    continuous = 1'b0;
    chk("cont_first_seen", (k1 >= 0) ? 1 : 0, 1);
    chk("cont_period_gap", k2 - k1, 40);
    chk("cont_overrun", int'(o_overrun), 1);
    chk("cont_result_valid", int'(o_result_valid), 1);
    result_ready = 1'b1;
    cycle();
    result_ready = 1'b0;
    chk("cont_consumed", int'(o_result_valid), 0);
    chk("cont_overrun_sticky", int'(o_overrun), 1);
    repeat (45) cycle();
    chk("cont_stopped", int'(o_busy), 0);

    // Asynchronous reset in the middle of SETTLE.
    start = 1'b1; sens_valid = 1'b1; sens_bit = 1'b1;
    cycle();
    start = 1'b0;
    repeat (RST + 2) cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sens_rst", int'(o_sens_rst), 1);
    chk("arst_sens_en", int'(o_sens_en), 0);
    chk("arst_busy", int'(o_busy), 0);
    chk("arst_result", int'(o_result), 0);
    chk("arst_result_valid", int'(o_result_valid), 0);
    chk("arst_overrun", int'(o_overrun), 0);
    model_reset();
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("arst_idle_wait", int'(o_busy), 0);
    run_vec(0, 0, lat, res);
    chk("arst_restart_latency", lat, 28);
    chk("arst_restart_result", res, 16);

    // New result loads on the exact handshake edge.
    result_ready = 1'b0; sens_valid = 1'b1; sens_bit = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (28) cycle();
    chk("hs_first_valid", int'(o_result_valid), 1);
    chk("hs_first_result", int'(o_result), 16);
    sens_bit = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (27) cycle();
    chk("hs_hold_result", int'(o_result), 16);
    result_ready = 1'b1;
    cycle();
    chk("hs_valid_kept", int'(o_result_valid), 1);
    chk("hs_new_result", int'(o_result), 0);
    chk("hs_no_overrun", int'(o_overrun), 0);
    cycle();
    chk("hs_consumed", int'(o_result_valid), 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      if (i % 400 == 0) begin
        continuous = 1'($urandom_range(0, 1));
        period     = 16'($urandom_range(0, 60));
      end
      start        = ($urandom_range(0, 15) == 0);
      abort        = ($urandom_range(0, 149) == 0);
      sens_valid   = ($urandom_range(0, 3) != 0);
      sens_bit     = 1'($urandom_range(0, 1));
      result_ready = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
